// File: rtl/pdm_modulator.sv
// First-order sigma-delta modulator: signed PCM in, 1-bit PDM stream plus bit clock out.
// Samples are pulled over a read/ready handshake and double-buffered (cur/nxt).
module pdm_modulator #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned OSR     = 64,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  output logic              pcm_read_o,
  input  logic              pcm_ready_i,
  input  logic [DATA_W-1:0] pcm_data_i,
  output logic              pdm_clk_o,
  output logic              pdm_data_o,
  output logic              underrun_o
);

  localparam int unsigned CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BCNT_W = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLK_DIV / 2);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(OSR - 1);
  localparam logic [DATA_W-1:0] MSB_ONLY  = {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic              pcm_read_q,  pcm_read_d;
  logic [DATA_W-1:0] nxt_q,       nxt_d;
  logic              nxt_valid_q, nxt_valid_d;
  logic [DATA_W-1:0] cur_q,       cur_d;
  logic [DATA_W-1:0] acc_q,       acc_d;
  logic              run_q,       run_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [BCNT_W-1:0] bcnt_q,      bcnt_d;
  logic              pdm_clk_q,   pdm_clk_d;
  logic              pdm_data_q,  pdm_data_d;
  logic              underrun_q,  underrun_d;

  logic              nxt_load_c;
  logic              consume_c;
  logic              tick_c;
  logic [DATA_W-1:0] off_c;
  logic [DATA_W:0]   sum_c;

  // Fetch FSM: keeps the nxt buffer filled whenever the modulator is enabled
  always_comb begin
    state_d    = state_q;
    pcm_read_d = 1'b0;
    nxt_d      = nxt_q;
    nxt_load_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i && !nxt_valid_q) begin
          state_d    = ST_REQ;
          pcm_read_d = 1'b1;
        end
      end
      ST_REQ: state_d = ST_WAIT;
      ST_WAIT: begin
        if (pcm_ready_i) begin
          nxt_d      = pcm_data_i;
          nxt_load_c = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Offset-binary sample; the carry out of the accumulator is the PDM bit
  assign off_c  = cur_q ^ MSB_ONLY;
  assign sum_c  = {1'b0, acc_q} + {1'b0, off_c};
  assign tick_c = (cnt_q == CNT_LAST);

  // Run control, bit-clock divider and modulator datapath
  always_comb begin
    run_d      = run_q;
    cur_d      = cur_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    pdm_clk_d  = pdm_clk_q;
    pdm_data_d = pdm_data_q;
    underrun_d = underrun_q;
    consume_c  = 1'b0;
    if (!enable_i) begin
      run_d      = 1'b0;
      acc_d      = '0;
      cnt_d      = '0;
      bcnt_d     = '0;
      pdm_clk_d  = 1'b0;
      pdm_data_d = 1'b0;
      underrun_d = 1'b0;
    end else if (!run_q) begin
      if (nxt_valid_q) begin
        run_d     = 1'b1;
        cur_d     = nxt_q;
        consume_c = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
        bcnt_d    = '0;
        pdm_clk_d = 1'b0;
      end
    end else begin
      cnt_d     = tick_c ? '0 : cnt_q + CNT_W'(1);
      pdm_clk_d = (cnt_d >= CNT_HALF);
      if (tick_c) begin
        pdm_data_d = sum_c[DATA_W];
        acc_d      = sum_c[DATA_W-1:0];
        if (bcnt_q == BCNT_LAST) begin
          // Sample boundary: swap in the buffered sample, or fall back to midscale
          bcnt_d = '0;
          if (nxt_valid_q) begin
            cur_d     = nxt_q;
            consume_c = 1'b1;
          end else begin
            cur_d      = '0;
            underrun_d = 1'b1;
          end
        end else begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
    end
  end

  // A load only happens while nxt is empty and a consume only while it is full
  assign nxt_valid_d = nxt_load_c ? 1'b1 : (consume_c ? 1'b0 : nxt_valid_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pcm_read_q  <= 1'b0;
      nxt_q       <= '0;
      nxt_valid_q <= 1'b0;
      cur_q       <= '0;
      acc_q       <= '0;
      run_q       <= 1'b0;
      cnt_q       <= '0;
      bcnt_q      <= '0;
      pdm_clk_q   <= 1'b0;
      pdm_data_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcm_read_q  <= pcm_read_d;
      nxt_q       <= nxt_d;
      nxt_valid_q <= nxt_valid_d;
      cur_q       <= cur_d;
      acc_q       <= acc_d;
      run_q       <= run_d;
      cnt_q       <= cnt_d;
      bcnt_q      <= bcnt_d;
      pdm_clk_q   <= pdm_clk_d;
      pdm_data_q  <= pdm_data_d;
      underrun_q  <= underrun_d;
    end
  end

  assign pcm_read_o = pcm_read_q;
  assign pdm_clk_o  = pdm_clk_q;
  assign pdm_data_o = pdm_data_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_pdm_modulator.sv
// Self-checking bench for pdm_modulator: a PCM source model feeds a sample scoreboard,
// and a bit-level accumulator model checks every PDM bit at each pdm_clk_o rise.
module tb_pdm_modulator;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned OSR     = 64;
  localparam int unsigned DATA_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              enable_i;
  logic              pcm_read_o;
  logic              pcm_ready_i;
  logic [DATA_W-1:0] pcm_data_i;
  logic              pdm_clk_o;
  logic              pdm_data_o;
  logic              underrun_o;

  pdm_modulator #(
    .CLK_DIV(CLK_DIV),
    .OSR    (OSR),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable_i),
    .pcm_read_o (pcm_read_o),
    .pcm_ready_i(pcm_ready_i),
    .pcm_data_i (pcm_data_i),
    .pdm_clk_o  (pdm_clk_o),
    .pdm_data_o (pdm_data_o),
    .underrun_o (underrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [DATA_W-1:0] samp_q[$];   // samples handed to the DUT, in play order
  logic [DATA_W-1:0] src_list[$];
  logic [DATA_W-1:0] src_default;
  bit                src_hold;
  int                rd_q[$];     // cycle numbers of pcm_read_o pulses
  int                win_q[$];    // observed ones per completed window

  bit                m_running;
  bit                m_underrun;
  logic [DATA_W-1:0] m_cur;
  int                m_acc;
  int                m_bit;
  int                m_ones;
  int                last_rise;
  logic              prev_pclk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_win(input int n, input int budget);
    int k;
    k = 0;
    while (win_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    chk("window_wait", 32'(win_q.size() >= n), 32'd1);
  endtask

  // PCM source: answers a request one cycle later unless held
  initial begin
    bit                req_seen;
    logic [DATA_W-1:0] v;
    req_seen    = 1'b0;
    pcm_ready_i = 1'b0;
    pcm_data_i  = '0;
    forever begin
      @(negedge clk);
      pcm_ready_i = 1'b0;
      if (rst_n !== 1'b1) begin
        req_seen = 1'b0;
      end else begin
        if (req_seen && !src_hold) begin
          if (src_list.size() > 0) v = src_list.pop_front();
          else v = src_default;
          pcm_ready_i = 1'b1;
          pcm_data_i  = v;
          samp_q.push_back(v);
          req_seen = 1'b0;
        end
        if (pcm_read_o === 1'b1) req_seen = 1'b1;
      end
    end
  end

  // Output monitor and reference model, sampled on the falling clk edge
  always @(negedge clk) begin
    int u;
    int sum;
    int exp_bit;
    if (rst_n === 1'b1) begin
      if (pcm_read_o === 1'b1) rd_q.push_back(cyc);
      if (pdm_clk_o === 1'b1 && prev_pclk === 1'b0) begin
        if (!m_running) begin
          // The first rise after start precedes the first emitted bit
          chk("start_sample_avail", 32'(samp_q.size() > 0), 32'd1);
          chk("lead_bit", 32'(pdm_data_o), 32'd0);
          if (samp_q.size() > 0) m_cur = samp_q.pop_front();
          m_acc = 0;
          m_bit = 0;
          m_ones = 0;
          m_running = 1'b1;
        end else begin
          chk("pdm_clk_period", 32'(cyc - last_rise), 32'(CLK_DIV));
          u = int'($signed(m_cur)) + 32768;
          sum = m_acc + u;
          exp_bit = (sum >= 65536) ? 1 : 0;
          m_acc = sum % 65536;
          chk("pdm_bit", 32'(pdm_data_o), 32'(exp_bit));
          if (pdm_data_o === 1'b1) m_ones++;
          m_bit++;
          if (m_bit == int'(OSR)) begin
            win_q.push_back(m_ones);
            m_ones = 0;
            m_bit = 0;
            if (samp_q.size() > 0) m_cur = samp_q.pop_front();
            else begin
              m_cur = '0;
              m_underrun = 1'b1;
            end
          end
          chk("underrun_track", 32'(underrun_o), 32'(m_underrun));
        end
        last_rise = cyc;
      end
      prev_pclk = pdm_clk_o;
    end else begin
      prev_pclk = 1'b0;
    end
  end

  initial begin
    int e;
    int n0;
    int k;
    m_running   = 1'b0;
    m_underrun  = 1'b0;
    src_hold    = 1'b0;
    src_default = 16'h4000;
    rst_n       = 1'b0;
    enable_i    = 1'b0;
    step(3);
    chk("rst_pcm_read", 32'(pcm_read_o), 32'd0);
    chk("rst_pdm_clk", 32'(pdm_clk_o), 32'd0);
    chk("rst_pdm_data", 32'(pdm_data_o), 32'd0);
    chk("rst_underrun", 32'(underrun_o), 32'd0);
    rst_n = 1'b1;
    step(5);
    chk("idle_no_read", 32'(rd_q.size()), 32'd0);

    // Windows: 0x0000, 0x8000, 0x7FFF, then steady 0x4000
    src_list.push_back(16'h0000);
    src_list.push_back(16'h8000);
    src_list.push_back(16'h7FFF);
    e = cyc;
    enable_i = 1'b1;
    step(8);
    chk("reads_after_start", 32'(rd_q.size()), 32'd2);
    if (rd_q.size() >= 2) begin
      chk("first_read_latency", 32'(rd_q[0] - e), 32'd1);
      chk("refill_read_gap", 32'(rd_q[1] - rd_q[0]), 32'd4);
    end
    wait_win(5, 2000);
    if (win_q.size() >= 5) begin
      chk("ones_0000", 32'(win_q[0]), 32'd32);
      chk("ones_8000", 32'(win_q[1]), 32'd0);
      chk("ones_7fff", 32'(win_q[2]), 32'd63);
      chk("ones_4000_a", 32'(win_q[3]), 32'd48);
      chk("ones_4000_b", 32'(win_q[4]), 32'd48);
    end
    if (rd_q.size() >= 5) begin
      chk("read_spacing_a", 32'(rd_q[2] - rd_q[1]), 32'(OSR * CLK_DIV));
      chk("read_spacing_b", 32'(rd_q[3] - rd_q[2]), 32'(OSR * CLK_DIV));
      chk("read_spacing_c", 32'(rd_q[4] - rd_q[3]), 32'(OSR * CLK_DIV));
    end
    chk("no_underrun_stream", 32'(underrun_o), 32'd0);

    // Underrun: withhold the next refill
    src_hold = 1'b1;
    k = 0;
    while (underrun_o !== 1'b1 && k < 1200) begin
      step(1);
      k++;
    end
    chk("underrun_set", 32'(underrun_o), 32'd1);
    step(40);
    enable_i = 1'b0;
    step(1);
    m_running  = 1'b0;
    m_underrun = 1'b0;
    chk("dis_pdm_clk", 32'(pdm_clk_o), 32'd0);
    chk("dis_pdm_data", 32'(pdm_data_o), 32'd0);
    chk("dis_underrun", 32'(underrun_o), 32'd0);
    src_list.push_back(16'h0000);
    src_hold = 1'b0;
    enable_i = 1'b1;
    n0 = win_q.size();
    wait_win(n0 + 1, 600);
    if (win_q.size() > n0) chk("ones_after_restart", 32'(win_q[n0]), 32'd32);
    chk("underrun_after_restart", 32'(underrun_o), 32'd0);

    // Async reset while the fetch FSM waits on a held request
    src_hold = 1'b1;
    k = 0;
    while (pcm_read_o !== 1'b1 && k < 600) begin
      step(1);
      k++;
    end
    chk("held_read_seen", 32'(pcm_read_o), 32'd1);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pcm_read", 32'(pcm_read_o), 32'd0);
    chk("mid_rst_pdm_clk", 32'(pdm_clk_o), 32'd0);
    chk("mid_rst_pdm_data", 32'(pdm_data_o), 32'd0);
    chk("mid_rst_underrun", 32'(underrun_o), 32'd0);
    samp_q.delete();
    rd_q.delete();
    m_running  = 1'b0;
    m_underrun = 1'b0;
    src_hold   = 1'b0;
    enable_i   = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_no_read", 32'(rd_q.size()), 32'd0);
    e = cyc;
    enable_i = 1'b1;
    step(4);
    chk("post_rst_read_seen", 32'(rd_q.size() >= 1), 32'd1);
    if (rd_q.size() >= 1) chk("post_rst_read_latency", 32'(rd_q[0] - e), 32'd1);
    n0 = win_q.size();
    wait_win(n0 + 1, 600);
    if (win_q.size() > n0) chk("ones_after_reset", 32'(win_q[n0]), 32'd48);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
